ram_64x8_ctrl: RTL and testbench
================================

# ram_64x8_ctrl

Access controller (initiator) for the 64x8 single-port RAM with registered address. It accepts single-word read or write requests on a valid/ready channel and sequences the RAM's two-phase protocol: latch the address with `we`=0, then write or sample `y`. It returns a response word on a second valid/ready channel. It sits between any client logic and the RAM instance, and is the only block that drives the RAM's `we`, `addr` and `data`.

## Interface
- `ADDR_WIDTH`, 6, RAM address width
- `DATA_WIDTH`, 8, RAM word width
- `DEPTH`, 64, number of RAM words; always equals 2**ADDR_WIDTH

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller accepts a request this cycle
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_WIDTH  target address
- `req_wdata`  in  DATA_WIDTH  write data (ignored for reads)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  client consumes the response
- `rsp_we`  out  1  echo of `req_we` for this response
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for write responses
- `mem_we`  out  1  drives RAM `we`
- `mem_addr`  out  ADDR_WIDTH  drives RAM `addr`
- `mem_data`  out  DATA_WIDTH  drives RAM `data`
- `mem_y`  in  DATA_WIDTH  RAM output `y`
- `init_done`  out  1  RAM clear sweep complete; tied 1 after START when the init feature is compiled out

## Operation
- RAM contract:
  - With `we`=0 at an edge, the RAM latches `addr`.
  - With `we`=1 at an edge, the RAM writes `data` to the previously latched address; `addr` is ignored.
  - `y` is a combinational read of the latched address.
- States: START, INIT_A, INIT_W, IDLE, SETA, XFER, RSP.
- START is the reset state. On the first edge after `rst_n` rises, it moves to INIT_A if the init feature is compiled in, otherwise to IDLE.
- IDLE:
  - `req_ready` = 1, and only in this state (combinational decode of state).
  - A handshake (`req_valid` & `req_ready`) registers `req_we`, `req_addr` and `req_wdata`, then moves to SETA.
- SETA:
  - Drives `mem_we`=0 and `mem_addr`=captured address.
  - Moves to XFER.
- XFER:
  - Write: `mem_we`=1 and `mem_data`=captured data.
  - Read: `mem_we`=0, address held. `mem_y` is registered into `rsp_rdata` at the end of XFER.
  - Moves to RSP.
- RSP:
  - `rsp_valid`=1; `rsp_we` and `rsp_rdata` are held stable.
  - `mem_we`=0 and `mem_addr` is held, so the RAM's latched address is unchanged.
  - `rsp_valid` & `rsp_ready` moves to IDLE.
- All outputs except `req_ready` are registered.
- Reset values: `rsp_valid`=0, `rsp_we`=0, `rsp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `init_done`=0, `req_ready`=0 (START).
- Reset mid-operation:
  - All state is aborted immediately and outputs take their reset values asynchronously.
  - A write whose XFER edge has not occurred is not performed.
  - There is no pending response after reset.
- Addresses are used unmodified and no arithmetic is applied. Any 6-bit value 0..63 is legal.

## Timing
- Request accepted at edge E0. SETA occupies E0..E1, XFER E1..E2. `rsp_valid` rises after E2.
- Accept-to-response latency is 3 cycles; the RAM write occurs at E2.
- Minimum throughput is one access per 4 cycles, with `rsp_ready` held high.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- Back-to-back: a new request can be accepted in the cycle immediately after the RSP handshake.

## Configuration
- Macro: `RAM_64X8_CTRL_INIT_EN`.
- Defined:
  - After START, the controller sweeps addresses 0..63. For each address, INIT_A drives `mem_we`=0 with `mem_addr`=i, and INIT_W drives `mem_we`=1 with `mem_data`=0.
  - The sweep takes 128 cycles. `init_done` rises and the state becomes IDLE on the edge that completes INIT_W for address 63.
  - `req_ready`=0 throughout the sweep.
- Not defined:
  - No INIT states exist; START goes to IDLE.
  - `init_done`=1 from the first edge after reset release.
  - RAM contents are uninitialized.

## Structure
- Shared package `ram_64x8_ctrl_pkg` holds:
  - the state enum;
  - localparams `ADDR_WIDTH`=6, `DATA_WIDTH`=8, `DEPTH`=64;
  - `INIT_WORD`=8'h00.
- No sub-module: the FSM, the capture registers and the 6-bit init counter live in one module.
- The RAM is instantiated beside the controller, not inside it.

## Test plan
- Reset, init feature compiled out: all outputs 0 during reset; `req_ready`=1 and `init_done`=1 one cycle after `rst_n` rises.
- Write 8'hA5 to 6'h2A, then read 6'h2A:
  - write response has `rsp_we`=1 and `rsp_rdata`=0, 3 cycles after accept;
  - read response has `rsp_rdata`=8'hA5.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during a read of 8'h3C. `rsp_valid`/`rsp_rdata` stay stable, `req_ready`=0 and `mem_we`=0 throughout.
- Boundary addresses: write 8'h11 to 63 and 8'h22 to 0, back to back. Reads return 8'h11 and 8'h22 respectively.
- `RAM_64X8_CTRL_INIT_EN`: preload the RAM with 8'hFF through a bench backdoor, then reset.
  - `init_done` rises 129 cycles after release (START plus 128);
  - reads of 0, 31 and 63 return 8'h00.
- Assert `rst_n` low during XFER of a write of 8'h77 to 5 (location previously 8'h10):
  - outputs reset immediately;
  - after re-init (init feature off), reading 5 returns 8'h10.

Source files
------------

// File: rtl/ram_64x8_ctrl_pkg.sv
// ============================================================================
// Module  : ram_64x8_ctrl_pkg
// Brief   : Shared types and constants for the 64x8 RAM access controller.
//           The INIT_A/INIT_W states exist only when RAM_64X8_CTRL_INIT_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ram_64x8_ctrl_pkg;

   localparam int ADDR_WIDTH = 6;
   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 64;

   localparam logic [DATA_WIDTH-1:0] INIT_WORD = 8'h00;

`ifdef RAM_64X8_CTRL_INIT_EN
   typedef enum logic [2:0] {
      START  = 3'd0,
      INIT_A = 3'd1,
      INIT_W = 3'd2,
      IDLE   = 3'd3,
      SETA   = 3'd4,
      XFER   = 3'd5,
      RSP    = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      START  = 3'd0,
      IDLE   = 3'd3,
      SETA   = 3'd4,
      XFER   = 3'd5,
      RSP    = 3'd6
   } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/ram_64x8_ctrl.sv
// ============================================================================
// Module  : ram_64x8_ctrl
// Brief   : Single-word read/write initiator for the 64x8 registered-address
//           RAM. Optional RAM clear sweep: define RAM_64X8_CTRL_INIT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ram_64x8_ctrl
   import ram_64x8_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_y,
   output logic                  init_done
);

   state_t                r_state;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_rsp_valid;
   logic                  r_rsp_we;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_data;
   logic                  r_init_done;
`ifdef RAM_64X8_CTRL_INIT_EN
   logic [ADDR_WIDTH-1:0] r_init_cnt;
`endif

   logic w_req_ready;

   assign w_req_ready = (r_state == IDLE);

   // mem_addr is loaded straight from req_addr on accept and then held, so the
   // RAM's latched address stays put through XFER and RSP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= START;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_init_done <= 1'b0;
`ifdef RAM_64X8_CTRL_INIT_EN
         r_init_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            START: begin
`ifdef RAM_64X8_CTRL_INIT_EN
               r_mem_we   <= 1'b0;
               r_mem_addr <= '0;
               r_init_cnt <= '0;
               r_state    <= INIT_A;
`else
               r_init_done <= 1'b1;
               r_state     <= IDLE;
`endif
            end
`ifdef RAM_64X8_CTRL_INIT_EN
            INIT_A: begin
               r_mem_we   <= 1'b1;
               r_mem_data <= INIT_WORD;
               r_state    <= INIT_W;
            end
            INIT_W: begin
               r_mem_we <= 1'b0;
               if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  r_init_done <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_init_cnt <= r_init_cnt + 1'b1;
                  r_mem_addr <= r_init_cnt + 1'b1;
                  r_state    <= INIT_A;
               end
            end
`endif
            IDLE: begin
               if (req_valid) begin
                  r_we       <= req_we;
                  r_wdata    <= req_wdata;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= req_addr;
                  r_state    <= SETA;
               end
            end
            SETA: begin
               r_mem_we <= r_we;
               if (r_we) begin
                  r_mem_data <= r_wdata;
               end
               r_state <= XFER;
            end
            XFER: begin
               r_mem_we    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_we    <= r_we;
               r_rsp_rdata <= r_we ? '0 : mem_y;
               r_state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_mem_we <= 1'b0;
               r_state  <= START;
            end
         endcase
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_we    = r_rsp_we;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_data  = r_mem_data;
   assign init_done = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_64x8_ctrl.sv
// ============================================================================
// Module  : tb_ram_64x8_ctrl
// Brief   : Self-checking bench for ram_64x8_ctrl with a behavioural RAM beside
//           it. Honours RAM_64X8_CTRL_INIT_EN when defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_64x8_ctrl;

`ifdef RAM_64X8_CTRL_INIT_EN
   localparam int INIT_CYC = 129;
`else
   localparam int INIT_CYC = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [5:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic       rsp_we;
   logic [7:0] rsp_rdata;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_data;
   logic [7:0] mem_y;
   logic       init_done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference contents: what the client should read back from each address.
   logic [7:0] ref_mem [64];
   bit         ref_known [64];

   always #5 clk = ~clk;

   ram_64x8_ctrl u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_y     (mem_y),
      .init_done (init_done)
   );

   // Behavioural 64x8 RAM with registered address and a fill backdoor.
   logic [7:0] ram [64];
   logic [5:0] ram_lat = '0;
   logic       bd_fill = 1'b0;

   always @(posedge clk) begin
      if (bd_fill) begin
         for (int i = 0; i < 64; i++) ram[i] <= 8'hFF;
      end else if (mem_we) begin
         ram[ram_lat] <= mem_data;
      end else begin
         ram_lat <= mem_addr;
      end
   end
   assign mem_y = ram[ram_lat];

   // All drivers run on the falling edge; every task starts and ends there.
   task automatic do_access(input logic we, input logic [5:0] a, input logic [7:0] d,
                            input int bp, output logic [7:0] rd, output logic rw,
                            output int lat);
      int n;
      rd = '0; rw = 1'b0; lat = -1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
         lat = -1;
         return;
      end
      rd = rsp_rdata;
      rw = rsp_we;
      repeat (bp) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset(input string tag, input bit fill);
      int n;
      rst_n = 1'b0;
      req_valid = 1'b0; rsp_ready = 1'b0;
      bd_fill = fill;
      repeat (2) @(negedge clk);
      bd_fill = 1'b0;
      if (fill) begin
         for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'hFF; ref_known[i] = 1'b1; end
      end
      n_cmp++;
      if ({rsp_valid, rsp_we, rsp_rdata, mem_we, mem_addr, mem_data, init_done, req_ready} !== 27'd0) begin
         n_err++;
         $display("FAIL %s_outputs_in_reset: rv=%b rw=%b rd=%h we=%b a=%h d=%h done=%b rdy=%b, required all 0",
                  tag, rsp_valid, rsp_we, rsp_rdata, mem_we, mem_addr, mem_data, init_done, req_ready);
      end
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!init_done && n < 400);
      n_cmp++;
      if (n !== INIT_CYC) begin
         n_err++;
         $display("FAIL %s_init_latency: init_done after %0d cycles, required %0d", tag, n, INIT_CYC);
      end
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle_after_init: req_ready=%b rsp_valid=%b, required 1/0", tag, req_ready, rsp_valid);
      end
`ifdef RAM_64X8_CTRL_INIT_EN
      for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'h00; ref_known[i] = 1'b1; end
`endif
   endtask

   task automatic test_reset();
      do_reset("reset", 1'b0);
   endtask

   task automatic test_write_read();
      logic [7:0] rd; logic rw; int lat;
      do_access(1'b1, 6'h2A, 8'hA5, 0, rd, rw, lat);
      ref_mem[6'h2A] = 8'hA5; ref_known[6'h2A] = 1'b1;
      n_cmp++;
      if (lat !== 3 || rw !== 1'b1 || rd !== 8'h00) begin
         n_err++;
         $display("FAIL write_rsp: lat=%0d we=%b rdata=%h, required 3/1/00", lat, rw, rd);
      end
      do_access(1'b0, 6'h2A, 8'h00, 0, rd, rw, lat);
      n_cmp++;
      if (lat !== 3 || rw !== 1'b0 || rd !== 8'hA5) begin
         n_err++;
         $display("FAIL read_rsp: lat=%0d we=%b rdata=%h, required 3/0/a5", lat, rw, rd);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] rd; logic rw; int lat; int n;
      do_access(1'b1, 6'h15, 8'h3C, 0, rd, rw, lat);
      ref_mem[6'h15] = 8'h3C; ref_known[6'h15] = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h15;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || req_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_hold[%0d]: rv=%b rdata=%h rdy=%b mem_we=%b, required 1/3c/0/0",
                     c, rsp_valid, rsp_rdata, req_ready, mem_we);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL backpressure_release: rv=%b rdy=%b, required 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic rw; int lat;
      do_access(1'b1, 6'd63, 8'h11, 0, rd, rw, lat);
      ref_mem[63] = 8'h11; ref_known[63] = 1'b1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_ready: req_ready=%b right after handshake, required 1", req_ready);
      end
      do_access(1'b1, 6'd0, 8'h22, 0, rd, rw, lat);
      ref_mem[0] = 8'h22; ref_known[0] = 1'b1;
      n_cmp++;
      if (lat !== 3) begin
         n_err++;
         $display("FAIL b2b_latency: lat=%0d, required 3", lat);
      end
      do_access(1'b0, 6'd63, 8'h00, 0, rd, rw, lat);
      n_cmp++;
      if (rd !== 8'h11) begin
         n_err++;
         $display("FAIL read_addr63: rdata=%h, required 11", rd);
      end
      do_access(1'b0, 6'd0, 8'h00, 0, rd, rw, lat);
      n_cmp++;
      if (rd !== 8'h22) begin
         n_err++;
         $display("FAIL read_addr0: rdata=%h, required 22", rd);
      end
   endtask

   task automatic test_random();
      logic [7:0] rd; logic rw; int lat;
      logic we; logic [5:0] a; logic [7:0] d; logic [7:0] exp_rd;
      for (int k = 0; k < 40; k++) begin
         a  = 6'($urandom_range(0, 63));
         d  = 8'($urandom);
         we = ref_known[a] ? 1'($urandom) : 1'b1;
         exp_rd = we ? 8'h00 : ref_mem[a];
         do_access(we, a, d, $urandom_range(0, 3), rd, rw, lat);
         if (we) begin ref_mem[a] = d; ref_known[a] = 1'b1; end
         n_cmp++;
         if (rd !== exp_rd || rw !== we || lat !== 3) begin
            n_err++;
            $display("FAIL random[%0d]: we=%b addr=%h got rdata=%h rsp_we=%b lat=%0d, required %h/%b/3",
                     k, we, a, rd, rw, lat, exp_rd, we);
         end
      end
   endtask

`ifdef RAM_64X8_CTRL_INIT_EN
   task automatic test_init();
      logic [7:0] rd; logic rw; int lat;
      logic [5:0] addrs [3];
      addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63;
      do_reset("init", 1'b1);
      for (int i = 0; i < 3; i++) begin
         do_access(1'b0, addrs[i], 8'h00, 0, rd, rw, lat);
         n_cmp++;
         if (rd !== 8'h00) begin
            n_err++;
            $display("FAIL init_clear[%0d]: rdata=%h, required 00", addrs[i], rd);
         end
      end
   endtask
`endif

   task automatic test_reset_abort();
      logic [7:0] rd; logic rw; int lat;
      do_access(1'b1, 6'd5, 8'h10, 0, rd, rw, lat);
      ref_mem[5] = 8'h10; ref_known[5] = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 8'h77;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_data !== 8'h77) begin
         n_err++;
         $display("FAIL abort_xfer_drive: mem_we=%b mem_data=%h, required 1/77", mem_we, mem_data);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_we, rsp_rdata, mem_we, mem_addr, mem_data, init_done, req_ready} !== 27'd0) begin
         n_err++;
         $display("FAIL abort_async_reset: rv=%b we=%b a=%h d=%h done=%b rdy=%b, required all 0",
                  rsp_valid, mem_we, mem_addr, mem_data, init_done, req_ready);
      end
      @(negedge clk);
      do_reset("abort", 1'b0);
      do_access(1'b0, 6'd5, 8'h00, 0, rd, rw, lat);
      n_cmp++;
      if (rd !== ref_mem[5]) begin
         n_err++;
         $display("FAIL abort_no_write: rdata=%h, required %h", rd, ref_mem[5]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin ref_mem[i] = 8'h00; ref_known[i] = 1'b0; end
      @(negedge clk);
      test_reset();
      test_write_read();
      test_backpressure();
      test_back_to_back();
      test_random();
`ifdef RAM_64X8_CTRL_INIT_EN
      test_init();
`endif
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
